l1_dc_wb_buf: RTL and testbench
===============================

// Module: l1_dc_wb_buf
// PURPOSE
//  Write-back buffer between the L1 dcache controller and L2, on the L2 side of the dcache.
//  - Captures each evicted dirty 128-bit line and its line address in one cycle.
//    The dcache therefore refills without waiting for L2 to absorb the victim.
//  - Drains entries to L2 one at a time, oldest first, over a req/rdy/complete handshake.
//  - Provides a combinational lookup, so a dcache refill sees victim data that has not yet drained.
// PARAMETERS
//  DEPTH   4    number of line entries (power of two, >=2)
//  PTR_W   2    log2(DEPTH)
//  ADDR_W  28   line address width (byte address [31:4])
//  LINE_W  128  line data width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  wb_req       in   1       dcache pushes a victim line this cycle
//  wb_addr      in   ADDR_W  victim line address
//  wb_data      in   LINE_W  victim line data
//  wb_full      out  1       registered; count==DEPTH
//  wb_empty     out  1       registered; count==0
//  wb_count     out  PTR_W+1 occupied entries
//  wb_overflow  out  1       sticky: push rejected while full
//  lookup_addr  in   ADDR_W  refill address from dcache
//  lookup_hit   out  1       combinational; a valid entry matches lookup_addr
//  lookup_data  out  LINE_W  data of the matching entry (0 when no hit)
//  l2_rdy       in   1       L2 accepts the current write request
//  l2_complete  in   1       L2 finished writing the accepted line (1-cycle pulse)
//  l2_wr_req    out  1       write request to L2
//  l2_wr_addr   out  ADDR_W  head entry address
//  l2_wr_data   out  LINE_W  head entry data
// BEHAVIOUR
//  Reset: pointers, count and valid bits = 0; FSM = IDLE; wb_empty=1; all other outputs 0.
//    Reset mid-drain abandons the transfer; L2 is reset in the same cycle.
//  Storage: circular FIFO with head (drain) and tail (fill) pointers. Both wrap at DEPTH-1 -> 0.
//  Push (wb_req=1). Evaluated in this order:
//    a) Merge: a valid entry matches wb_addr and is not the in-flight head.
//       Its data is overwritten and count is unchanged. At most one entry can match.
//    b) Allocate: otherwise, if count<DEPTH or a pop occurs this cycle, write at tail,
//       advance tail, count+1 (net 0 with a pop).
//    c) Reject: otherwise the push is dropped and wb_overflow is set (cleared only by rst).
//  Drain FSM:
//    IDLE: count>0 -> REQ. l2_wr_req=0.
//    REQ: l2_wr_req=1, addr/data = head entry, held stable until l2_rdy=1 is sampled -> WAIT.
//    WAIT: l2_wr_req=0; head is in flight. On l2_complete: pop head (valid=0, head+1, count-1) -> IDLE.
//    l2_complete in IDLE/REQ is ignored.
//  Minimum cycles per line: IDLE->REQ 1, REQ->WAIT >=1, WAIT->pop >=1.
//    A back-to-back next line reasserts l2_wr_req 2 cycles after the pop.
//  Simultaneous push and pop when full: the push is accepted, count stays DEPTH.
//  Lookup:
//    - Compares all valid entries, including the in-flight head.
//    - The head stays valid until the pop, so a refill racing a drain still hits.
//    - A push merged this cycle is not visible to lookup until the next cycle.
//  Arithmetic: count is PTR_W+1 bits and never exceeds DEPTH. Pointers are PTR_W bits, wrap modulo DEPTH.
// TESTING
//  1. Reset, then push A=0x0000010 / D=0x11..11 -> count=1 next cycle.
//     l2_wr_req=1 two cycles after the push, with addr=0x0000010. l2_rdy 1 cycle later -> req drops.
//     l2_complete -> count=0, wb_empty=1.
//  2. l2_rdy held 0: push 4 distinct lines -> wb_full=1.
//     A 5th push -> rejected, wb_overflow=1, count=4, entries unchanged.
//  3. Full and in WAIT: push coincident with l2_complete -> accepted, count stays 4.
//     Tail wraps to 0; the drain order is preserved.
//  4. Push A/D1, then A/D2 while A is not the head in flight -> count=1, drained data=D2.
//     Repeat with A in WAIT -> new entry, count=2, both D1 then D2 reach L2.
//  5. Lookup address equals the in-flight head -> lookup_hit=1 with the head data.
//     The cycle after l2_complete -> lookup_hit=0, lookup_data=0.
//  6. Assert rst during REQ with 3 entries -> next cycle l2_wr_req=0, count=0, wb_overflow=0, FSM IDLE.

Source files
------------

// File: rtl/l1_dc_wb_buf.sv
// Write-back buffer between the L1 dcache and L2: captures dirty victims in one cycle,
// drains them oldest-first over req/rdy/complete, and serves refill lookups until drained.
module l1_dc_wb_buf #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    output logic              wb_full,
    output logic              wb_empty,
    output logic [PTR_W:0]    wb_count,
    output logic              wb_overflow,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    input  logic              l2_rdy,
    input  logic              l2_complete,
    output logic              l2_wr_req,
    output logic [ADDR_W-1:0] l2_wr_addr,
    output logic [LINE_W-1:0] l2_wr_data
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LINE_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              in_flight;
    logic              pop;
    logic              merge_hit;
    logic [PTR_W-1:0]  merge_idx;
    logic              do_merge;
    logic              do_alloc;
    logic              do_reject;
    logic [CNT_W-1:0]  count_next;
    logic [LINE_W-1:0] head_data_next;

    // Push classification: merge into a resident victim, allocate at tail, or reject.
    always_comb begin
        in_flight = (state != IDLE);
        pop       = (state == WAIT) && l2_complete;
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i] && (addr_mem[i] == wb_addr) && !(in_flight && (PTR_W'(i) == head))) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(i);
            end
        end
        do_merge   = wb_req && merge_hit;
        do_alloc   = wb_req && !merge_hit && ((wb_count < CNT_W'(DEPTH)) || pop);
        do_reject  = wb_req && !merge_hit && !do_alloc;
        count_next = wb_count + CNT_W'(do_alloc) - CNT_W'(pop);
        // A merge landing on the head in the launch cycle must reach L2, not the stale copy.
        head_data_next = (do_merge && (merge_idx == head)) ? wb_data : data_mem[head];
    end

    // Lookup sees the stored state only; same-cycle merges appear next cycle.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i] && (addr_mem[i] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_merge) begin
            data_mem[merge_idx] <= wb_data;
        end else if (do_alloc) begin
            addr_mem[tail] <= wb_addr;
            data_mem[tail] <= wb_data;
        end
    end

    // Pointers, occupancy, status flags and the drain FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid       <= '0;
            head        <= '0;
            tail        <= '0;
            wb_count    <= '0;
            wb_full     <= 1'b0;
            wb_empty    <= 1'b1;
            wb_overflow <= 1'b0;
            l2_wr_req   <= 1'b0;
            l2_wr_addr  <= '0;
            l2_wr_data  <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            // Allocation after pop so a full-buffer push into the freed slot stays valid.
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (do_reject) begin
                wb_overflow <= 1'b1;
            end
            wb_count <= count_next;
            wb_full  <= (count_next == CNT_W'(DEPTH));
            wb_empty <= (count_next == '0);

            case (state)
                IDLE: begin
                    if (wb_count != '0) begin
                        state      <= REQ;
                        l2_wr_req  <= 1'b1;
                        l2_wr_addr <= addr_mem[head];
                        l2_wr_data <= head_data_next;
                    end
                end
                REQ: begin
                    if (l2_rdy) begin
                        state     <= WAIT;
                        l2_wr_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (l2_complete) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    l2_wr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dc_wb_buf.sv
// Scoreboard bench for l1_dc_wb_buf: accepted victims are queued at push time and
// checked in order as L2 accepts each write request.
module tb_l1_dc_wb_buf;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 128;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_req = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [LINE_W-1:0] wb_data = '0;
    logic              wb_full;
    logic              wb_empty;
    logic [PTR_W:0]    wb_count;
    logic              wb_overflow;
    logic [ADDR_W-1:0] lookup_addr = '0;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic              l2_rdy = 1'b0;
    logic              l2_complete = 1'b0;
    logic              l2_wr_req;
    logic [ADDR_W-1:0] l2_wr_addr;
    logic [LINE_W-1:0] l2_wr_data;

    int  n_cmp = 0;
    int  n_err = 0;
    sb_t sb_q[$];
    sb_t mon_exp;

    l1_dc_wb_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_full(wb_full), .wb_empty(wb_empty), .wb_count(wb_count), .wb_overflow(wb_overflow),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .l2_rdy(l2_rdy), .l2_complete(l2_complete),
        .l2_wr_req(l2_wr_req), .l2_wr_addr(l2_wr_addr), .l2_wr_data(l2_wr_data)
    );

    always #5 clk = ~clk;

    // L2 acceptance monitor: the request accepted at the next edge must match the oldest queued victim.
    always @(negedge clk) begin
        if (!rst && l2_wr_req && l2_rdy) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL drain_unexpected: got addr=%h data=%h, required no request", l2_wr_addr, l2_wr_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (l2_wr_addr !== mon_exp.addr || l2_wr_data !== mon_exp.data) begin
                    n_err++;
                    $display("FAIL drain_order: got addr=%h data=%h, required addr=%h data=%h",
                             l2_wr_addr, l2_wr_data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb_req = 1'b0;
        l2_rdy = 1'b0;
        l2_complete = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        wb_req  = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_req  = 1'b0;
    endtask

    // Waits (bounded) for a request, then grants it for one cycle; leaves the DUT in WAIT.
    task automatic l2_accept();
        bit seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (l2_wr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: got l2_wr_req=%b, required 1 within 20 cycles", l2_wr_req);
        end
        l2_rdy = 1'b1;
        tick();
        l2_rdy = 1'b0;
    endtask

    task automatic l2_finish();
        l2_complete = 1'b1;
        tick();
        l2_complete = 1'b0;
    endtask

    task automatic drain_one();
        l2_accept();
        l2_finish();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({wb_empty, wb_full, wb_count, wb_overflow, l2_wr_req} !== 7'b1_0_000_0_0) begin
            n_err++;
            $display("FAIL reset_flags: got empty=%b full=%b count=%0d ovf=%b req=%b, required 1 0 0 0 0",
                     wb_empty, wb_full, wb_count, wb_overflow, l2_wr_req);
        end
        n_cmp++;
        if (l2_wr_addr !== '0 || l2_wr_data !== '0 || lookup_hit !== 1'b0 || lookup_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h data=%h hit=%b ldata=%h, required all 0",
                     l2_wr_addr, l2_wr_data, lookup_hit, lookup_data);
        end
    endtask

    task automatic test_single();
        logic [LINE_W-1:0] d = {16{8'h11}};
        do_reset();
        sb_q.push_back('{addr: 28'h0000010, data: d});
        push(28'h0000010, d);
        n_cmp++;
        if (wb_count !== 3'd1 || wb_empty !== 1'b0 || l2_wr_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_count: got count=%0d empty=%b req=%b, required 1 0 0", wb_count, wb_empty, l2_wr_req);
        end
        tick();
        n_cmp++;
        if (l2_wr_req !== 1'b1 || l2_wr_addr !== 28'h0000010) begin
            n_err++;
            $display("FAIL single_req: got req=%b addr=%h, required 1 0000010", l2_wr_req, l2_wr_addr);
        end
        l2_rdy = 1'b1;
        tick();
        l2_rdy = 1'b0;
        n_cmp++;
        if (l2_wr_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_req_drop: got req=%b, required 0", l2_wr_req);
        end
        l2_finish();
        n_cmp++;
        if (wb_count !== 3'd0 || wb_empty !== 1'b1 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL single_pop: got count=%0d empty=%b pending=%0d, required 0 1 0", wb_count, wb_empty, sb_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [LINE_W-1:0] d [5];
        do_reset();
        for (int i = 0; i < 5; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{addr: ADDR_W'(28'h100 + i), data: d[i]});
            push(ADDR_W'(28'h100 + i), d[i]);
        end
        n_cmp++;
        if (wb_full !== 1'b1 || wb_count !== 3'd4 || wb_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_full: got full=%b count=%0d ovf=%b, required 1 4 0", wb_full, wb_count, wb_overflow);
        end
        push(28'h104, d[4]);
        n_cmp++;
        if (wb_overflow !== 1'b1 || wb_count !== 3'd4 || wb_full !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_reject: got ovf=%b count=%0d full=%b, required 1 4 1", wb_overflow, wb_count, wb_full);
        end
        lookup_addr = 28'h104;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_lookup_rejected: got hit=%b, required 0", lookup_hit);
        end
        lookup_addr = 28'h103;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b1 || lookup_data !== d[3]) begin
            n_err++;
            $display("FAIL ovf_lookup_kept: got hit=%b data=%h, required 1 %h", lookup_hit, lookup_data, d[3]);
        end
        for (int i = 0; i < 4; i++) drain_one();
        n_cmp++;
        if (wb_empty !== 1'b1 || wb_overflow !== 1'b1 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL ovf_sticky: got empty=%b ovf=%b pending=%0d, required 1 1 0", wb_empty, wb_overflow, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] dn;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dn = {4{32'hA000_0000 + 32'(i)}};
            sb_q.push_back('{addr: ADDR_W'(28'h200 + i), data: dn});
            push(ADDR_W'(28'h200 + i), dn);
        end
        l2_accept();
        dn = {4{32'hBEEF_0004}};
        sb_q.push_back('{addr: 28'h204, data: dn});
        wb_req = 1'b1;
        wb_addr = 28'h204;
        wb_data = dn;
        l2_complete = 1'b1;
        tick();
        wb_req = 1'b0;
        l2_complete = 1'b0;
        n_cmp++;
        if (wb_count !== 3'd4 || wb_full !== 1'b1 || wb_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop: got count=%0d full=%b ovf=%b, required 4 1 0", wb_count, wb_full, wb_overflow);
        end
        n_cmp++;
        if (l2_wr_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: got req=%b, required 0 in the cycle after the pop", l2_wr_req);
        end
        tick();
        n_cmp++;
        if (l2_wr_req !== 1'b1 || l2_wr_addr !== 28'h201) begin
            n_err++;
            $display("FAIL b2b_reassert: got req=%b addr=%h, required 1 0000201", l2_wr_req, l2_wr_addr);
        end
        lookup_addr = 28'h200;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b0) begin
            n_err++;
            $display("FAIL popped_lookup: got hit=%b, required 0", lookup_hit);
        end
        for (int i = 0; i < 4; i++) drain_one();
        n_cmp++;
        if (wb_empty !== 1'b1 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_drain: got empty=%b pending=%0d, required 1 0", wb_empty, sb_q.size());
        end
    endtask

    task automatic test_merge();
        logic [LINE_W-1:0] d1 = {4{32'hD1D1_D1D1}};
        logic [LINE_W-1:0] d2 = {4{32'hD2D2_D2D2}};
        do_reset();
        sb_q.push_back('{addr: 28'h300, data: d2});
        push(28'h300, d1);
        push(28'h300, d2);
        n_cmp++;
        if (wb_count !== 3'd1) begin
            n_err++;
            $display("FAIL merge_count: got count=%0d, required 1", wb_count);
        end
        drain_one();
        sb_q.push_back('{addr: 28'h300, data: d1});
        push(28'h300, d1);
        l2_accept();
        sb_q.push_back('{addr: 28'h300, data: d2});
        push(28'h300, d2);
        n_cmp++;
        if (wb_count !== 3'd2) begin
            n_err++;
            $display("FAIL inflight_alloc: got count=%0d, required 2", wb_count);
        end
        l2_finish();
        drain_one();
        n_cmp++;
        if (wb_empty !== 1'b1 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL merge_drain: got empty=%b pending=%0d, required 1 0", wb_empty, sb_q.size());
        end
    endtask

    task automatic test_lookup();
        logic [LINE_W-1:0] d = {4{32'h5A5A_0001}};
        logic [LINE_W-1:0] e = {4{32'h6B6B_0002}};
        do_reset();
        sb_q.push_back('{addr: 28'h400, data: d});
        push(28'h400, d);
        l2_accept();
        lookup_addr = 28'h400;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b1 || lookup_data !== d) begin
            n_err++;
            $display("FAIL lookup_head: got hit=%b data=%h, required 1 %h", lookup_hit, lookup_data, d);
        end
        l2_finish();
        n_cmp++;
        if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
            n_err++;
            $display("FAIL lookup_after_pop: got hit=%b data=%h, required 0 0", lookup_hit, lookup_data);
        end
        lookup_addr = 28'h401;
        wb_req = 1'b1;
        wb_addr = 28'h401;
        wb_data = e;
        #1;
        n_cmp++;
        if (lookup_hit !== 1'b0) begin
            n_err++;
            $display("FAIL lookup_same_cycle: got hit=%b, required 0", lookup_hit);
        end
        tick();
        wb_req = 1'b0;
        n_cmp++;
        if (lookup_hit !== 1'b1 || lookup_data !== e) begin
            n_err++;
            $display("FAIL lookup_next_cycle: got hit=%b data=%h, required 1 %h", lookup_hit, lookup_data, e);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push(ADDR_W'(28'h500 + i), {4{32'(i)}});
        n_cmp++;
        if (l2_wr_req !== 1'b1 || wb_count !== 3'd3) begin
            n_err++;
            $display("FAIL pre_reset: got req=%b count=%0d, required 1 3", l2_wr_req, wb_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (l2_wr_req !== 1'b0 || wb_count !== 3'd0 || wb_overflow !== 1'b0 || wb_empty !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got req=%b count=%0d ovf=%b empty=%b, required 0 0 0 1",
                     l2_wr_req, wb_count, wb_overflow, wb_empty);
        end
        sb_q.push_back('{addr: 28'h600, data: {4{32'h600}}});
        push(28'h600, {4{32'h600}});
        tick();
        n_cmp++;
        if (l2_wr_req !== 1'b1 || l2_wr_addr !== 28'h600) begin
            n_err++;
            $display("FAIL post_reset_req: got req=%b addr=%h, required 1 0000600", l2_wr_req, l2_wr_addr);
        end
        drain_one();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_merge();
        test_lookup();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
